// File: rtl/neptuno_joy_scanner.sv
// Serial joystick scanner for the Neptuno 2 shift-register chain.
// Alternates JOY_SEL between frames: the H frame (SEL=1) yields directions
// plus B/C, the L frame (SEL=0) yields Megadrive detect plus A/Start.
// joy1/joy2 only change after a complete L frame, so a partial frame or a
// mismatched H/L pair is never presented to the core.
// There is no valid/ready handshake: joy_valid is a one-cycle strobe with
// no back-pressure, and joy1/joy2 stay stable until the next strobe.
module neptuno_joy_scanner #(
  parameter int CLK_DIV   = 250,
  parameter int GAP_TICKS = 4
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       JOY_DATA,
  output logic       JOY_CLK,
  output logic       JOY_LOAD,
  output logic       JOY_SEL,
  output logic [8:0] joy1,
  output logic [8:0] joy2,
  output logic       joy_valid,
  output logic [1:0] o_dbg_state
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(GAP_TICKS);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // tick generator
  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  // input synchronizer
  logic r_sync1;
  logic r_sync2;

  // sequencer
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_bit;
  logic [3:0]       w_bit_nxt;
  logic             r_half;
  logic             w_half_nxt;
  logic             w_sample;
  logic             w_frame_done;
  logic             w_clk_nxt;
  logic             w_load_nxt;

  // chain pins
  logic r_clk;
  logic r_load;
  logic r_sel;

  // capture, staging and results
  logic [15:0] r_frame;
  logic [5:0]  r_stage1;
  logic [5:0]  r_stage2;
  logic [8:0]  r_joy1;
  logic [8:0]  r_joy2;
  logic        r_valid;
  logic        w_md1;
  logic        w_md2;
  logic [8:0]  w_l_word1;
  logic [8:0]  w_l_word2;
  logic        w_unused_bits;

  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

  // Free-running divider producing one tick per JOY_CLK half-period.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous chain output.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= JOY_DATA;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic; only applied on ticks. Pin levels are decoded from
  // the next state so the pins are registered alongside the state.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_half_nxt   = r_half;
    w_sample     = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      ST_LOAD: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 4'd0;
          w_half_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!r_half) begin
          // End of the low half: data has settled since the falling edge.
          w_sample   = 1'b1;
          w_half_nxt = 1'b1;
        end else if (r_bit == 4'd15) begin
          w_state_nxt  = ST_GAP;
          w_cnt_nxt    = '0;
          w_half_nxt   = 1'b0;
          w_frame_done = 1'b1;
        end else begin
          w_bit_nxt  = r_bit + 4'd1;
          w_half_nxt = 1'b0;
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_W'(GAP_TICKS - 1)) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_GAP;
        w_cnt_nxt   = '0;
      end
    endcase
    w_clk_nxt  = (w_state_nxt == ST_SHIFT) && w_half_nxt;
    w_load_nxt = (w_state_nxt != ST_LOAD);
  end

  // Sequencer state register, advanced on ticks only.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state <= ST_GAP;
      r_cnt   <= '0;
      r_bit   <= 4'd0;
      r_half  <= 1'b0;
    end else if (w_tick) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_half  <= w_half_nxt;
    end
  end

  // Chain control pins; SEL flips on the tick that ends a frame.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_clk  <= 1'b0;
      r_load <= 1'b1;
      r_sel  <= 1'b1;
    end else if (w_tick) begin
      r_clk  <= w_clk_nxt;
      r_load <= w_load_nxt;
      if (w_frame_done) begin
        r_sel <= ~r_sel;
      end
    end
  end

  // Frame capture; buttons are active low on the wire, stored active high.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_frame <= '0;
    end else if (w_tick && w_sample) begin
      r_frame[r_bit] <= ~r_sync2;
    end
  end

  // A pad is Megadrive when Left and Right read pressed in the L frame.
  assign w_md1     = r_frame[2] & r_frame[3];
  assign w_md2     = r_frame[10] & r_frame[11];
  assign w_l_word1 = {w_md1, w_md1 & r_frame[5], w_md1 & r_frame[4], r_stage1};
  assign w_l_word2 = {w_md2, w_md2 & r_frame[13], w_md2 & r_frame[12], r_stage2};

  // The unused chain positions are shifted in but carry no buttons.
  assign w_unused_bits = ^{r_frame[7:6], r_frame[15:14]};

  // Stage the H frame; publish H+L together when an L frame completes.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_stage1 <= '0;
      r_stage2 <= '0;
      r_joy1   <= '0;
      r_joy2   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_tick && w_frame_done) begin
        if (r_sel) begin
          r_stage1 <= r_frame[5:0];
          r_stage2 <= r_frame[13:8];
        end else begin
          r_joy1  <= w_l_word1;
          r_joy2  <= w_l_word2;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign JOY_CLK     = r_clk;
  assign JOY_LOAD    = r_load;
  assign JOY_SEL     = r_sel;
  assign joy1        = r_joy1;
  assign joy2        = r_joy2;
  assign joy_valid   = r_valid;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_neptuno_joy_scanner.sv
// Bench for neptuno_joy_scanner: a full-speed instance (CLK_DIV=250) for
// pin timing and an Atari pad, and a minimum-divider instance for Megadrive
// decoding, reset mid-frame and random patterns. Each instance is fed by a
// behavioural 74HC165 chain model whose parallel inputs follow JOY_SEL.
module tb_neptuno_joy_scanner;

  // ---------------- clock / counters ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [17:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {joy2, joy1} from active-low H and L chain patterns.
  function automatic logic [17:0] model(input logic [15:0] h, input logic [15:0] l);
    logic [17:0] r;
    logic [7:0]  hb;
    logic [7:0]  lb;
    logic        md;
    r = '0;
    for (int p = 0; p < 2; p++) begin
      hb = ~h[8*p +: 8];
      lb = ~l[8*p +: 8];
      md = lb[2] & lb[3];
      r[9*p +: 9] = {md, md & lb[5], md & lb[4], hb[5:0]};
    end
    return r;
  endfunction

  // ---------------- instance A: CLK_DIV=250, GAP_TICKS=4 ----------------
  logic        a_rst_n = 1'b0;
  logic        a_data;
  logic        a_jclk, a_jload, a_jsel, a_valid;
  logic [8:0]  a_joy1, a_joy2;
  logic [1:0]  a_dbg;
  logic [15:0] a_h = 16'hFFFF;
  logic [15:0] a_l = 16'hFFFF;
  logic [15:0] a_sh = 16'hFFFF;
  logic        a_pclk = 1'b0;

  neptuno_joy_scanner #(.CLK_DIV(250), .GAP_TICKS(4)) u_dut_a (
    .CLOCK_50   (clk),
    .RESET_N    (a_rst_n),
    .JOY_DATA   (a_data),
    .JOY_CLK    (a_jclk),
    .JOY_LOAD   (a_jload),
    .JOY_SEL    (a_jsel),
    .joy1       (a_joy1),
    .joy2       (a_joy2),
    .joy_valid  (a_valid),
    .o_dbg_state(a_dbg)
  );

  always @(posedge clk) begin
    if (!a_jload) a_sh <= a_jsel ? a_h : a_l;
    else if (a_jclk && !a_pclk) a_sh <= {1'b1, a_sh[15:1]};
    a_pclk <= a_jclk;
  end
  assign a_data = a_sh[0];

  // ---------------- instance B: CLK_DIV=4, GAP_TICKS=2 ----------------
  logic        b_rst_n = 1'b0;
  logic        b_data;
  logic        b_jclk, b_jload, b_jsel, b_valid;
  logic [8:0]  b_joy1, b_joy2;
  logic [1:0]  b_dbg;
  logic [15:0] b_h = 16'hFFFF;
  logic [15:0] b_l = 16'hFFFF;
  logic [15:0] b_sh = 16'hFFFF;
  logic        b_pclk = 1'b0;

  neptuno_joy_scanner #(.CLK_DIV(4), .GAP_TICKS(2)) u_dut_b (
    .CLOCK_50   (clk),
    .RESET_N    (b_rst_n),
    .JOY_DATA   (b_data),
    .JOY_CLK    (b_jclk),
    .JOY_LOAD   (b_jload),
    .JOY_SEL    (b_jsel),
    .joy1       (b_joy1),
    .joy2       (b_joy2),
    .joy_valid  (b_valid),
    .o_dbg_state(b_dbg)
  );

  always @(posedge clk) begin
    if (!b_jload) b_sh <= b_jsel ? b_h : b_l;
    else if (b_jclk && !b_pclk) b_sh <= {1'b1, b_sh[15:1]};
    b_pclk <= b_jclk;
  end
  assign b_data = b_sh[0];

  // ---------------- driver tasks ----------------
  // Waits for the next joy_valid on instance B; n = cycles waited or -1.
  task automatic b_wait_valid(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (b_valid) break;
    end
    if (!b_valid) n = -1;
  endtask

  task automatic run_a();
    int cyc, t_fall, t_rise, t_sel, t_c1, t_c2, t_v1, t_v2;
    int rises, nvalid, vcycles;
    logic in_frame, sel_seen, p_load, p_clk, p_sel, p_valid;
    a_h = 16'hFFEE;  // port 1 Up + F1 pressed
    a_l = 16'hFFEE;
    a_rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check_val("a_rst_load", a_jload, 1);
    check_val("a_rst_clk", a_jclk, 0);
    check_val("a_rst_sel", a_jsel, 1);
    check_val("a_rst_joy1", a_joy1, 0);
    check_val("a_rst_joy2", a_joy2, 0);
    check_val("a_rst_valid", a_valid, 0);
    a_rst_n = 1'b1;
    cyc = 0; t_fall = -1; t_rise = -1; t_sel = -1; t_c1 = -1; t_c2 = -1;
    t_v1 = -1; t_v2 = -1; rises = 0; nvalid = 0; vcycles = 0;
    in_frame = 1'b0; sel_seen = 1'b0;
    p_load = 1'b1; p_clk = 1'b0; p_sel = 1'b1; p_valid = 1'b0;
    while (cyc < 40000 && nvalid < 2) begin
      @(negedge clk);
      cyc++;
      if (p_load && !a_jload && t_fall < 0) t_fall = cyc;
      if (!p_load && a_jload && t_rise < 0) begin
        t_rise = cyc;
        in_frame = 1'b1;
      end
      if (!p_clk && a_jclk) begin
        if (in_frame) rises++;
        if (t_c1 < 0) t_c1 = cyc;
        else if (t_c2 < 0) t_c2 = cyc;
      end
      if (p_sel != a_jsel && !sel_seen) begin
        sel_seen = 1'b1;
        in_frame = 1'b0;
        t_sel = cyc;
      end
      if (a_valid) begin
        vcycles++;
        if (!p_valid) begin
          nvalid++;
          if (nvalid == 1) t_v1 = cyc;
          else t_v2 = cyc;
          check_val("a_atari_joy1", a_joy1, 9'h011);
          check_val("a_atari_joy2", a_joy2, 9'h000);
        end
      end
      p_load = a_jload; p_clk = a_jclk; p_sel = a_jsel; p_valid = a_valid;
    end
    @(negedge clk);
    check_val("a_valid_width", a_valid, 0);
    check_val("a_first_load_fall", t_fall, 1000);
    check_val("a_load_low_len", t_rise - t_fall, 500);
    check_val("a_clk_rises", rises, 16);
    check_val("a_clk_period", t_c2 - t_c1, 500);
    check_val("a_first_sel_toggle", t_sel, 9500);
    check_val("a_first_valid", t_v1, 19000);
    check_val("a_valid_period", t_v2 - t_v1, 19000);
    check_val("a_valid_cycles", vcycles, 2);
  endtask

  task automatic run_b();
    int n, rises;
    logic p_clk;
    logic [15:0] ph, pl;
    b_h = 16'hFFEE;
    b_l = 16'hFFEE;
    b_rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check_val("b_rst_load", b_jload, 1);
    check_val("b_rst_sel", b_jsel, 1);
    check_val("b_rst_joy1", b_joy1, 0);
    check_val("b_rst_valid", b_valid, 0);
    b_rst_n = 1'b1;
    b_wait_valid(1000, n);
    check_val("b_first_valid", n, 288);
    check_val("b_atari_joy1", b_joy1, 9'h011);
    check_val("b_atari_joy2", b_joy2, 9'h000);

    // Megadrive pad on port 2.
    b_h = 16'hF7FF;  // Right
    b_l = 16'hC3FF;  // Left, Right, F1, F2
    b_wait_valid(400, n);
    check_val("b_md_period", n, 288);
    check_val("b_md_joy2", b_joy2, 9'h1C8);
    check_val("b_md_joy1", b_joy1, 9'h000);
    b_l = 16'hC7FF;  // Left released
    b_wait_valid(400, n);
    check_val("b_md_noleft_joy2", b_joy2, 9'h008);

    // Reset at bit 7 of an L frame.
    rises = 0; n = 0; p_clk = b_jclk;
    while (n < 800) begin
      @(negedge clk);
      n++;
      if (!b_jload) rises = 0;
      else if (!p_clk && b_jclk && !b_jsel) rises++;
      p_clk = b_jclk;
      if (rises == 7 && !b_jclk && !b_jsel) break;
    end
    check_val("b_found_l_bit7", n < 800, 1);
    b_rst_n = 1'b0;
    @(negedge clk);
    check_val("b_midrst_joy2", b_joy2, 0);
    check_val("b_midrst_joy1", b_joy1, 0);
    check_val("b_midrst_valid", b_valid, 0);
    check_val("b_midrst_sel", b_jsel, 1);
    b_rst_n = 1'b1;
    b_wait_valid(1000, n);
    check_val("b_after_rst_valid", n, 288);
    check_val("b_after_rst_joy2", b_joy2, 9'h008);

    // Random static patterns, one scan each.
    for (int s = 0; s < 50; s++) begin
      ph = 16'($urandom_range(0, 65535));
      pl = 16'($urandom_range(0, 65535));
      b_h = ph;
      b_l = pl;
      exp_q.push_back(model(ph, pl));
      b_wait_valid(400, n);
      if (n < 0) check_val("b_rand_timeout", n, 288);
      else check_val("b_rand_joy", {b_joy2, b_joy1}, exp_q.pop_front());
    end
  endtask

  // ---------------- main / report ----------------
  initial begin
    fork
      run_a();
      run_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
